// File: rtl/hgw_pkg.sv
// Shared defaults and width-dependent limit helpers for the sign-restore block.
package hgw_pkg;

  localparam int I_W_DEFAULT   = 16;
  localparam int CNT_W_DEFAULT = 8;

  // Largest positive two's-complement value representable in 'width' bits.
  function automatic logic [31:0] max_pos(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Bit pattern of the most negative two's-complement value in 'width' bits,
  // which is also the largest magnitude a negative result can carry.
  function automatic logic [31:0] min_neg(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/hgw_pipe_stage.sv
// One valid/ready register slice. It accepts a new beat whenever it is empty
// or its current beat leaves this cycle, so back-to-back slices collapse
// bubbles and a stalled slice holds its payload untouched.
module hgw_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         vld_q;
  logic [W-1:0] data_q;

  assign in_rdy   = !rst && (!vld_q || out_rdy);
  assign out_vld  = vld_q;
  assign out_data = data_q;

  // Load a beat when the slot is free or draining; reset empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_rdy) begin
      vld_q <= in_vld;
      if (in_vld) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/hgw_sign_restore.sv
// Applies a sign to an unsigned magnitude and produces a saturated
// two's-complement result through two register slices, counting how many
// clamped beats were delivered downstream.
module hgw_sign_restore
  import hgw_pkg::*;
#(
  parameter int I_W   = I_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [I_W-1:0]   i_mag,
  input  logic             i_sgn,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [I_W-1:0]   o,
  output logic             o_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [I_W-1:0]   MAX_POS = I_W'(max_pos(I_W));
  localparam logic [I_W-1:0]   MIN_NEG = I_W'(min_neg(I_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               S1_W    = I_W + 3;
  localparam int               S2_W    = I_W + 1;

  logic            above_pos;
  logic            above_neg;
  logic [S1_W-1:0] s1_in;
  logic [S1_W-1:0] s1_out;
  logic            s1_vld;
  logic            s2_in_rdy;
  logic            s1_above_pos;
  logic            s1_above_neg;
  logic            s1_sgn;
  logic [I_W-1:0]  s1_mag;
  logic [I_W-1:0]  res;
  logic            res_sat;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_out;

  // Range flags are resolved before the first slice so the second half of
  // the pipe only has to pick between the negated value and a limit.
  assign above_pos = i_mag > MAX_POS;
  assign above_neg = i_mag > MIN_NEG;
  assign s1_in     = {above_neg, above_pos, i_sgn, i_mag};

  hgw_pipe_stage #(.W(S1_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (i_vld),
    .in_rdy   (i_rdy),
    .in_data  (s1_in),
    .out_vld  (s1_vld),
    .out_rdy  (s2_in_rdy),
    .out_data (s1_out)
  );

  assign {s1_above_neg, s1_above_pos, s1_sgn, s1_mag} = s1_out;

  // Apply the sign; magnitudes beyond the representable range clamp to the
  // matching limit. A magnitude of exactly MIN_NEG negates to itself, and a
  // negative zero negates to plain zero, so neither needs a special case.
  always_comb begin
    res     = s1_mag;
    res_sat = 1'b0;
    if (s1_sgn) begin
      if (s1_above_neg) begin
        res     = MIN_NEG;
        res_sat = 1'b1;
      end else begin
        res = (~s1_mag) + I_W'(1);
      end
    end else if (s1_above_pos) begin
      res     = MAX_POS;
      res_sat = 1'b1;
    end
  end

  assign s2_in = {res_sat, res};

  hgw_pipe_stage #(.W(S2_W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (s1_vld),
    .in_rdy   (s2_in_rdy),
    .in_data  (s2_in),
    .out_vld  (o_vld),
    .out_rdy  (o_rdy),
    .out_data (s2_out)
  );

  assign {o_sat, o} = s2_out;

  // Count clamped beats as they leave; sticks at all-ones and a clear beats
  // a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sat_cnt <= '0;
    end else if (o_vld && o_rdy && o_sat && (sat_cnt != CNT_MAX)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hgw_sign_restore.sv
// Directed bench for hgw_sign_restore: reset, sign application, clamping,
// backpressure, counter saturation/clear, mid-stream reset, and round trip.
module tb_hgw_sign_restore;

  localparam int I_W   = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_vld;
  logic             i_rdy;
  logic [I_W-1:0]   i_mag;
  logic             i_sgn;
  logic             o_vld;
  logic             o_rdy;
  logic [I_W-1:0]   o;
  logic             o_sat;
  logic             cnt_clr;
  logic [CNT_W-1:0] sat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hgw_sign_restore #(.I_W(I_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (i_vld),
    .i_rdy   (i_rdy),
    .i_mag   (i_mag),
    .i_sgn   (i_sgn),
    .o_vld   (o_vld),
    .o_rdy   (o_rdy),
    .o       (o),
    .o_sat   (o_sat),
    .cnt_clr (cnt_clr),
    .sat_cnt (sat_cnt)
  );

  task automatic test_reset;
    rst = 1'b1; i_vld = 1'b0; i_mag = '0; i_sgn = 1'b0; o_rdy = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (i_rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_i_rdy got=%b want=0", i_rdy); end
    total++; if (o_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_vld got=%b want=0", o_vld); end
    total++; if (o !== 16'h0000) begin bad++; $display("[TB] FAIL reset_o got=%h want=0000", o); end
    total++; if (o_sat !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_sat got=%b want=0", o_sat); end
    total++; if (sat_cnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_sat_cnt got=%0d want=0", sat_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (i_rdy !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_i_rdy got=%b want=1", i_rdy); end
    total++; if (o_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_o_vld got=%b want=0", o_vld); end
  endtask

  task automatic test_basic;
    logic [15:0] mags [4] = '{16'd5, 16'd5, 16'h8000, 16'd0};
    logic        sgns [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] exps [4] = '{16'h0005, 16'hFFFB, 16'h8000, 16'h0000};
    o_rdy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 2 && c <= 5) begin
        total++; if (o_vld !== 1'b1) begin bad++; $display("[TB] FAIL basic_o_vld c=%0d got=%b want=1", c, o_vld); end
        total++; if (o !== exps[c-2]) begin bad++; $display("[TB] FAIL basic_o c=%0d got=%h want=%h", c, o, exps[c-2]); end
        total++; if (o_sat !== 1'b0) begin bad++; $display("[TB] FAIL basic_o_sat c=%0d got=%b want=0", c, o_sat); end
      end else begin
        total++; if (o_vld !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle c=%0d got=%b want=0", c, o_vld); end
      end
      if (c < 4) begin
        i_vld = 1'b1; i_mag = mags[c]; i_sgn = sgns[c];
      end else begin
        i_vld = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sat;
    logic [15:0] mags [2] = '{16'h8000, 16'h8001};
    logic        sgns [2] = '{1'b0, 1'b1};
    logic [15:0] exps [2] = '{16'h7FFF, 16'h8000};
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    @(negedge clk);
    total++; if (sat_cnt !== 2'd0) begin bad++; $display("[TB] FAIL sat_clear got=%0d want=0", sat_cnt); end
    for (int c = 0; c < 6; c++) begin
      if (c == 2 || c == 3) begin
        total++; if (o_vld !== 1'b1) begin bad++; $display("[TB] FAIL sat_o_vld c=%0d got=%b want=1", c, o_vld); end
        total++; if (o !== exps[c-2]) begin bad++; $display("[TB] FAIL sat_o c=%0d got=%h want=%h", c, o, exps[c-2]); end
        total++; if (o_sat !== 1'b1) begin bad++; $display("[TB] FAIL sat_o_sat c=%0d got=%b want=1", c, o_sat); end
      end
      if (c < 2) begin
        i_vld = 1'b1; i_mag = mags[c]; i_sgn = sgns[c];
      end else begin
        i_vld = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (sat_cnt !== 2'd2) begin bad++; $display("[TB] FAIL sat_cnt got=%0d want=2", sat_cnt); end
  endtask

  task automatic test_backpressure;
    logic [15:0] mags [8] = '{16'd3, 16'd3, 16'h7FFF, 16'h1234, 16'h0100, 16'd1, 16'h8000, 16'h7FFF};
    logic        sgns [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exps [8] = '{16'h0003, 16'hFFFD, 16'h7FFF, 16'hEDCC, 16'h0100, 16'hFFFF, 16'h7FFF, 16'h8001};
    int          in_idx  = 0;
    int          out_idx = 0;
    logic [15:0] held    = '0;
    logic        held_v  = 1'b0;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      o_rdy = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        total++; if (i_rdy !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall_i_rdy c=%0d got=%b want=0", c, i_rdy); end
      end
      if (c == 6) begin
        total++; if (i_rdy !== 1'b1) begin bad++; $display("[TB] FAIL bp_resume_i_rdy got=%b want=1", i_rdy); end
      end
      if (held_v) begin
        total++;
        if (o_vld !== 1'b1 || o !== held) begin
          bad++; $display("[TB] FAIL bp_hold c=%0d got=%b/%h want=1/%h", c, o_vld, o, held);
        end
      end
      held_v = 1'b0;
      if (o_vld === 1'b1) begin
        if (o_rdy) begin
          total++;
          if (out_idx >= 8) begin
            bad++; $display("[TB] FAIL bp_extra got=%h want=none", o);
          end else if (o !== exps[out_idx]) begin
            bad++; $display("[TB] FAIL bp_order idx=%0d got=%h want=%h", out_idx, o, exps[out_idx]);
          end
          out_idx++;
        end else begin
          held = o; held_v = 1'b1;
        end
      end
      if (in_idx < 8) begin
        i_vld = 1'b1; i_mag = mags[in_idx]; i_sgn = sgns[in_idx];
      end else begin
        i_vld = 1'b0;
      end
      if (i_vld && i_rdy === 1'b1) in_idx++;
      @(negedge clk);
    end
    i_vld = 1'b0; o_rdy = 1'b1;
    total++; if (out_idx != 8) begin bad++; $display("[TB] FAIL bp_count got=%0d want=8", out_idx); end
    @(negedge clk);
  endtask

  task automatic test_cnt_sat;
    o_rdy = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c <= 6) begin
        total++;
        if (o_vld !== 1'b1 || o !== 16'h7FFF || o_sat !== 1'b1) begin
          bad++; $display("[TB] FAIL cnt_beat c=%0d got=%b/%h/%b want=1/7fff/1", c, o_vld, o, o_sat);
        end
      end
      if (c < 5) begin
        i_vld = 1'b1; i_mag = 16'hFFFF; i_sgn = 1'b0;
      end else begin
        i_vld = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (sat_cnt !== 2'd3) begin bad++; $display("[TB] FAIL cnt_hold got=%0d want=3", sat_cnt); end
    i_vld = 1'b1; i_mag = 16'h9000; i_sgn = 1'b1;
    @(negedge clk);
    i_vld = 1'b0;
    @(negedge clk);
    total++;
    if (o_vld !== 1'b1 || o !== 16'h8000 || o_sat !== 1'b1) begin
      bad++; $display("[TB] FAIL cnt_sixth got=%b/%h/%b want=1/8000/1", o_vld, o, o_sat);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    total++; if (sat_cnt !== 2'd0) begin bad++; $display("[TB] FAIL cnt_clr_wins got=%0d want=0", sat_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_flush;
    o_rdy = 1'b1;
    i_vld = 1'b1; i_mag = 16'h0011; i_sgn = 1'b0;
    @(negedge clk);
    i_mag = 16'h0022;
    @(negedge clk);
    total++;
    if (o_vld !== 1'b1 || o !== 16'h0011) begin
      bad++; $display("[TB] FAIL flush_pre got=%b/%h want=1/0011", o_vld, o);
    end
    rst = 1'b1; i_vld = 1'b0;
    #1;
    total++; if (i_rdy !== 1'b0) begin bad++; $display("[TB] FAIL flush_rst_i_rdy got=%b want=0", i_rdy); end
    @(negedge clk);
    total++;
    if (o_vld !== 1'b0 || o !== 16'h0000 || o_sat !== 1'b0) begin
      bad++; $display("[TB] FAIL flush_cleared got=%b/%h/%b want=0/0000/0", o_vld, o, o_sat);
    end
    rst = 1'b0;
    #1;
    total++; if (i_rdy !== 1'b1) begin bad++; $display("[TB] FAIL flush_i_rdy got=%b want=1", i_rdy); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (o_vld !== 1'b0) begin bad++; $display("[TB] FAIL flush_stale c=%0d got=%b/%h want=0", c, o_vld, o); end
    end
  endtask

  task automatic test_inverse;
    logic [15:0] xs [40];
    logic [15:0] x;
    int          in_idx  = 0;
    int          out_idx = 0;
    xs[0] = 16'h8000; xs[1] = 16'h7FFF; xs[2] = 16'hFFFF; xs[3] = 16'h0001;
    for (int k = 4; k < 40; k++) xs[k] = 16'($urandom_range(0, 65535));
    for (int c = 0; c < 400 && out_idx < 40; c++) begin
      o_rdy = ($urandom_range(0, 3) != 0);
      #1;
      if (o_vld === 1'b1 && o_rdy) begin
        total++;
        if (out_idx >= 40) begin
          bad++; $display("[TB] FAIL inv_extra got=%h want=none", o);
        end else if (o !== xs[out_idx] || o_sat !== 1'b0) begin
          bad++; $display("[TB] FAIL inv_value idx=%0d got=%h/%b want=%h/0", out_idx, o, o_sat, xs[out_idx]);
        end
        out_idx++;
      end
      if (in_idx < 40) begin
        x = xs[in_idx];
        i_vld = 1'b1;
        i_sgn = x[15];
        i_mag = x[15] ? (~x + 16'd1) : x;
      end else begin
        i_vld = 1'b0;
      end
      if (i_vld && i_rdy === 1'b1) in_idx++;
      @(negedge clk);
    end
    i_vld = 1'b0; o_rdy = 1'b1;
    total++; if (out_idx != 40) begin bad++; $display("[TB] FAIL inv_count got=%0d want=40", out_idx); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired=1 want=0");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_backpressure();
    test_cnt_sat();
    test_reset_flush();
    test_inverse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
